sync_fifo_ram: RTL

SYNC_FIFO_RAM -- requirements
Module: sync_fifo_ram

---
 rtl/sync_fifo_ram.sv | 110 +++++++++++
 1 files changed

// File: rtl/sync_fifo_ram.sv
// Synchronous FIFO over a DEPTH x WIDTH register array with a registered read port.
// Optional sticky overflow/underflow flags are enabled by SYNC_FIFO_RAM_ERR_FLAGS_EN.
module sync_fifo_ram #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int ADDR_SIZE = 4,
  parameter int AF_LEVEL  = 14,
  parameter int AE_LEVEL  = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clr,
  input  logic                 we,
  input  logic                 re,
  input  logic [WIDTH-1:0]     din,
  output logic [WIDTH-1:0]     dout,
  output logic                 rd_valid,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic [ADDR_SIZE:0]   count,
  output logic                 overflow,
  output logic                 underflow
);

  localparam logic [ADDR_SIZE:0]   CNT_FULL = DEPTH[ADDR_SIZE:0];
  localparam logic [ADDR_SIZE:0]   CNT_AF   = AF_LEVEL[ADDR_SIZE:0];
  localparam logic [ADDR_SIZE:0]   CNT_AE   = AE_LEVEL[ADDR_SIZE:0];
  localparam logic [ADDR_SIZE:0]   CNT_ONE  = 1;
  localparam logic [ADDR_SIZE-1:0] PTR_ONE  = 1;

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [ADDR_SIZE-1:0] wr_ptr;
  logic [ADDR_SIZE-1:0] rd_ptr;
  logic                 wr_ok;
  logic                 rd_ok;

  // Status is decoded from the registered count only, never from we/re.
  always_comb begin
    full         = (count == CNT_FULL);
    empty        = (count == '0);
    almost_full  = (count >= CNT_AF);
    almost_empty = (count <= CNT_AE);
  end

  always_comb begin
    wr_ok = we && !full  && !clr;
    rd_ok = re && !empty && !clr;
  end

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
      dout     <= '0;
    end else if (clr) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_ok;
      if (wr_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (rd_ok) begin
        dout   <= mem[rd_ptr];
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (wr_ok && !rd_ok) begin
        count <= count + CNT_ONE;
      end else if (rd_ok && !wr_ok) begin
        count <= count - CNT_ONE;
      end
    end
  end

`ifdef SYNC_FIFO_RAM_ERR_FLAGS_EN
  // Flags see raw requests against the pre-edge status; clr wins over a same-edge set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clr) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (we && full) begin
        overflow <= 1'b1;
      end
      if (re && empty) begin
        underflow <= 1'b1;
      end
    end
  end
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule
